chip_bus_arbiter: RTL and testbench
===================================

# chip_bus_arbiter

Cycle-level arbiter for the shared chip bus between the 68000 and Agnus DMA. It divides the 28.63636 MHz master clock into 8-clock chip-bus slots (one colour-clock period each) and decodes CPU cycles by A[23:21]. For each CPU cycle it either grants a free slot or holds the CPU off while DMA owns the bus. It drives the RAM, register, ROM and VPA enables and _DTACK that the PALEN/PALCAS pair would otherwise produce.

## Interface
- SLOT_LEN, 8, master clocks per chip-bus slot (power of two, ≥4)
- ROM_WAIT, 4, clocks from ROM select to _DTACK
- BLS_SLOTS, 3, consecutive denied slots before _BLS asserts
- DTACK_PHASE, 3, slot phase at which _DTACK asserts for a chip/register access
- CLK  in  1  28.63636 MHz master clock; all inputs synchronous to it
- RST  in  1  synchronous, active-high reset
- _AS  in  1  CPU address strobe, active low
- A  in  3  CPU A[23:21]
- OVL  in  1  boot overlay from CIA-A PA0
- _OVR  in  1  external override, active low
- XRDY  in  1  external ready, active high
- _DBR  in  1  Agnus DMA bus request, active low
- PHASE  out  log2(SLOT_LEN)  slot phase counter
- _RE  out  1  chip RAM enable, active low
- _RGAE  out  1  custom register enable, active low
- _ROME  out  1  ROM enable, active low
- _VPA  out  1  CIA/6800 cycle request, active low
- _DTACK  out  1  data acknowledge, active low
- _BLS  out  1  blitter-slow request to Agnus, active low

## Operation
- PHASE counts 0..SLOT_LEN-1 every CLK and wraps. A slot starts at PHASE==0.
- Decode is taken from the registered A while in DECODE:
  - 000: chip RAM, or ROM when OVL=1.
  - 110: custom registers.
  - 101: CIA.
  - 111: ROM.
  - 001, 010, 011, 100: external.
- States: IDLE, DECODE, WAIT_SLOT, CHIP, ROM, VPA, EXT, HOLD, RELEASE.
- IDLE → DECODE when _AS=0.
- DECODE transitions:
  - chip/register → WAIT_SLOT.
  - ROM → ROM.
  - CIA → VPA.
  - external with _OVR=1 → EXT.
  - external with _OVR=0 → RELEASE; the block drives nothing and an external device owns the cycle.
- WAIT_SLOT, at PHASE==0: _DBR=1 → CHIP; _DBR=0 → slot denied, deny counter +1.
- CHIP: _RE or _RGAE (by region) is low for the whole slot, PHASE 0..SLOT_LEN-1. _DTACK goes low at PHASE==DTACK_PHASE. At PHASE==SLOT_LEN-1 the enable releases and the state moves to HOLD.
- ROM: _ROME goes low on entry. _DTACK goes low ROM_WAIT clocks after entry, then the state moves to HOLD; _ROME stays low in HOLD.
- VPA: _VPA stays low until _AS=1. _DTACK is never asserted for this access.
- EXT: _DTACK goes low on the first clock XRDY=1 is sampled, then the state moves to HOLD. There is no timeout.
- HOLD: _DTACK (and _ROME for ROM) stays low until _AS=1, then the state moves to IDLE.
- RELEASE: waits for _AS=1, then IDLE.
- Deny counter (width ≥ log2(BLS_SLOTS)+1, saturating):
  - cleared on entry to CHIP and on return to IDLE.
  - _BLS=0 while counter ≥ BLS_SLOTS.
- Abort: _AS=1 in DECODE, WAIT_SLOT, ROM or EXT → IDLE next clock. All outputs deassert that clock and the deny counter clears.
- Abort in CHIP: the enable completes the slot, then the state moves to IDLE.

## Timing
- Reset (RST=1 at a CLK edge):
  - PHASE=0, state IDLE, deny counter 0.
  - _RE=_RGAE=_ROME=_VPA=_DTACK=_BLS=1.
  - Reset overrides any in-progress access, including mid-slot CHIP.
- All outputs are registered and change only on CLK rising edges.
- Latency, _AS low at edge n:
  - DECODE at n+1.
  - Earliest CHIP entry at the first PHASE==0 edge after n+1.
  - _DTACK at CHIP entry + DTACK_PHASE clocks.
  - Best-case _AS→_DTACK is DTACK_PHASE+2 clocks; worst case with a free bus is SLOT_LEN+DTACK_PHASE+1.
- _DBR is sampled only at PHASE==0. Changes mid-slot never preempt a granted CHIP slot.
- _DBR=0 and _AS=0 together at a slot start: DMA wins, every time.
- OVL and _OVR are sampled only in DECODE. Changes during an access have no effect until the next cycle.
- Every enable, _VPA and _DTACK return to 1 within one clock after HOLD, VPA or RELEASE sees _AS=1 (CHIP exception above).

## Test plan
- Reset: hold RST=1 for 3 clocks mid-CHIP, with _RE low at PHASE 5 → all outputs 1, PHASE 0, state IDLE on the following edge.
- Free chip access: _AS=0 at PHASE 6 with A=000, OVL=0, _DBR=1 → _RE low PHASE 0..7 of the next slot; _DTACK low at PHASE 3; _DTACK high 1 clock after _AS=1.
- DMA contention: _DBR=0 for 4 slots, CPU requesting A=110 → _RGAE held high; _BLS low from the 3rd denied slot start; after _DBR=1, CHIP granted and _BLS high again.
- Overlay/ROM: OVL=1, A=000 → _ROME low one clock after DECODE, _DTACK 4 clocks later, _RE never asserted; repeat with OVL=0 → chip path.
- CIA and external: A=101 → _VPA low until _AS=1, _DTACK stays 1. A=010, _OVR=1, XRDY rising after 10 clocks → _DTACK low the clock XRDY is sampled high. A=010, _OVR=0 → no outputs asserted.
- Abort: _AS=0 then _AS=1 while in WAIT_SLOT with _DBR=0 → IDLE next clock, no enable asserted, deny counter 0.

Source files
------------

// File: rtl/chip_bus_arbiter.sv
// Chip-bus slot arbiter between the 68000 and Agnus DMA: times CPU cycles into
// colour-clock slots and generates the RAM/register/ROM/VPA enables and DTACK.
module chip_bus_arbiter #(
  parameter int unsigned SLOT_LEN    = 8,
  parameter int unsigned ROM_WAIT    = 4,
  parameter int unsigned BLS_SLOTS   = 3,
  parameter int unsigned DTACK_PHASE = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        as_n,
  input  logic [2:0]                  a,
  input  logic                        ovl,
  input  logic                        ovr_n,
  input  logic                        xrdy,
  input  logic                        dbr_n,
  output logic [$clog2(SLOT_LEN)-1:0] phase,
  output logic                        re_n,
  output logic                        rgae_n,
  output logic                        rome_n,
  output logic                        vpa_n,
  output logic                        dtack_n,
  output logic                        bls_n
);

  localparam int unsigned PHASE_W = $clog2(SLOT_LEN);
  localparam int unsigned DENY_W  = $clog2(BLS_SLOTS) + 1;
  localparam int unsigned WAIT_W  = $clog2(ROM_WAIT) + 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_DECODE, ST_WAIT_SLOT, ST_CHIP, ST_ROM,
    ST_VPA, ST_EXT, ST_HOLD, ST_RELEASE
  } state_e;

  typedef enum logic [2:0] {RG_RAM, RG_REG, RG_ROM, RG_CIA, RG_EXT} region_e;

  state_e              state_q, state_d;
  region_e             region_q, region_d, region_dec;
  logic [2:0]          a_q, a_d;
  logic [DENY_W-1:0]   deny_q, deny_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                abort_q, abort_d;
  logic [PHASE_W-1:0]  phase_d;
  logic                slot_end;
  logic                re_d, rgae_d, rome_d, vpa_d, dtack_d, bls_d;

  // Address map of the latched CPU address; OVL turns page 0 into ROM.
  always_comb begin
    case (a_q)
      3'b000:  region_dec = ovl ? RG_ROM : RG_RAM;
      3'b110:  region_dec = RG_REG;
      3'b101:  region_dec = RG_CIA;
      3'b111:  region_dec = RG_ROM;
      default: region_dec = RG_EXT;
    endcase
  end

  assign phase_d  = phase + PHASE_W'(1);
  assign slot_end = (phase == PHASE_W'(SLOT_LEN - 1));

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    a_d      = a_q;
    deny_d   = deny_q;
    wait_d   = wait_q;
    abort_d  = abort_q;
    re_d     = 1'b1;
    rgae_d   = 1'b1;
    rome_d   = 1'b1;
    vpa_d    = 1'b1;
    dtack_d  = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (!as_n) begin
          state_d = ST_DECODE;
          a_d     = a;
        end
      end

      ST_DECODE: begin
        region_d = region_dec;
        if (as_n) begin
          state_d = ST_IDLE;
        end else begin
          unique case (region_dec)
            RG_RAM, RG_REG: state_d = ST_WAIT_SLOT;
            RG_ROM: begin
              state_d = ST_ROM;
              rome_d  = 1'b0;
              wait_d  = '0;
            end
            RG_CIA: begin
              state_d = ST_VPA;
              vpa_d   = 1'b0;
            end
            RG_EXT: state_d = ovr_n ? ST_EXT : ST_RELEASE;
          endcase
        end
      end

      // The slot boundary is the edge where the phase wraps back to zero.
      ST_WAIT_SLOT: begin
        if (as_n) begin
          state_d = ST_IDLE;
        end else if (slot_end) begin
          if (dbr_n) begin
            state_d = ST_CHIP;
            deny_d  = '0;
            abort_d = 1'b0;
            dtack_d = 1'(DTACK_PHASE != 0);
            if (region_q == RG_REG) rgae_d = 1'b0;
            else                    re_d   = 1'b0;
          end else if (deny_q != {DENY_W{1'b1}}) begin
            deny_d = deny_q + DENY_W'(1);
          end
        end
      end

      // A granted slot always runs to completion; a CPU abort only drops DTACK.
      ST_CHIP: begin
        abort_d = abort_q | as_n;
        if (slot_end) begin
          state_d = abort_d ? ST_IDLE : ST_HOLD;
          dtack_d = abort_d;
        end else begin
          if (region_q == RG_REG) rgae_d = 1'b0;
          else                    re_d   = 1'b0;
          dtack_d = ~((phase_d >= PHASE_W'(DTACK_PHASE)) & ~abort_d);
        end
      end

      ST_ROM: begin
        if (as_n) begin
          state_d = ST_IDLE;
        end else begin
          rome_d = 1'b0;
          if (wait_q == WAIT_W'(ROM_WAIT - 1)) begin
            dtack_d = 1'b0;
            state_d = ST_HOLD;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end

      ST_VPA: begin
        if (as_n) state_d = ST_IDLE;
        else      vpa_d   = 1'b0;
      end

      ST_EXT: begin
        if (as_n) begin
          state_d = ST_IDLE;
        end else if (xrdy) begin
          dtack_d = 1'b0;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (as_n) begin
          state_d = ST_IDLE;
        end else begin
          dtack_d = 1'b0;
          rome_d  = ~(region_q == RG_ROM);
        end
      end

      ST_RELEASE: begin
        if (as_n) state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_IDLE) deny_d = '0;
    bls_d = ~(deny_d >= DENY_W'(BLS_SLOTS));
  end

  // State, slot phase and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      region_q <= RG_RAM;
      a_q      <= '0;
      deny_q   <= '0;
      wait_q   <= '0;
      abort_q  <= 1'b0;
      phase    <= '0;
      re_n     <= 1'b1;
      rgae_n   <= 1'b1;
      rome_n   <= 1'b1;
      vpa_n    <= 1'b1;
      dtack_n  <= 1'b1;
      bls_n    <= 1'b1;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      a_q      <= a_d;
      deny_q   <= deny_d;
      wait_q   <= wait_d;
      abort_q  <= abort_d;
      phase    <= phase_d;
      re_n     <= re_d;
      rgae_n   <= rgae_d;
      rome_n   <= rome_d;
      vpa_n    <= vpa_d;
      dtack_n  <= dtack_d;
      bls_n    <= bls_d;
    end
  end

endmodule

// File: tb/tb_chip_bus_arbiter.sv
// Bench for chip_bus_arbiter: directed and random CPU cycles whose expected
// waveforms are computed per cycle from slot arithmetic.
module tb_chip_bus_arbiter;

  localparam int SLOT = 8;
  localparam int DTP  = 3;
  localparam int ROMW = 4;
  localparam int BLS  = 3;

  logic       clk = 1'b0;
  logic       rst, as_n, ovl, ovr_n, xrdy, dbr_n;
  logic [2:0] a;
  logic [2:0] phase;
  logic       re_n, rgae_n, rome_n, vpa_n, dtack_n, bls_n;

  int errors = 0;
  int checks = 0;
  int ph = 0;

  chip_bus_arbiter #(
    .SLOT_LEN(SLOT), .ROM_WAIT(ROMW), .BLS_SLOTS(BLS), .DTACK_PHASE(DTP)
  ) dut (
    .clk(clk), .rst(rst), .as_n(as_n), .a(a), .ovl(ovl), .ovr_n(ovr_n),
    .xrdy(xrdy), .dbr_n(dbr_n), .phase(phase), .re_n(re_n), .rgae_n(rgae_n),
    .rome_n(rome_n), .vpa_n(vpa_n), .dtack_n(dtack_n), .bls_n(bls_n)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_all(input int k, input logic e_re, input logic e_rgae, input logic e_rome,
                         input logic e_vpa, input logic e_dt, input logic e_bls);
    chk("phase", k, 8'(phase), 8'(ph));
    chk("re_n", k, 8'(re_n), 8'(e_re));
    chk("rgae_n", k, 8'(rgae_n), 8'(e_rgae));
    chk("rome_n", k, 8'(rome_n), 8'(e_rome));
    chk("vpa_n", k, 8'(vpa_n), 8'(e_vpa));
    chk("dtack_n", k, 8'(dtack_n), 8'(e_dt));
    chk("bls_n", k, 8'(bls_n), 8'(e_bls));
  endtask

  task automatic idle_to(input int target);
    while (ph != target) begin
      as_n = 1'b1; a = 3'($urandom); dbr_n = 1'($urandom);
      xrdy = 1'($urandom); ovl = 1'($urandom); ovr_n = 1'($urandom);
      @(posedge clk); #1;
      ph = (ph + 1) % SLOT;
      chk_all(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    end
  endtask

  // One CPU cycle; edge 1 is the edge that first samples as_n low.
  // kind: 0 RAM, 1 registers, 2 ROM, 3 CIA, 4 external, 5 released to external.
  task automatic run_txn(input logic [2:0] code, input logic ovl_s, input logic ovr_s,
                         input int ndeny, input int xdel, input int hold, input int abort_at);
    int p0, s0, g, r, t, base, last, kind, deny;
    logic gr, en, dt;
    p0 = ph;
    case (code)
      3'd0:    kind = ovl_s ? 2 : 0;
      3'd6:    kind = 1;
      3'd5:    kind = 3;
      3'd7:    kind = 2;
      default: kind = ovr_s ? 4 : 5;
    endcase
    s0 = 3;
    while ((p0 + s0) % SLOT != 0) s0++;
    g = s0 + SLOT * ndeny;
    t = (xdel > 3) ? xdel : 3;
    if (kind <= 1)      base = g + DTP;
    else if (kind == 2) base = 2 + ROMW;
    else if (kind == 4) base = t;
    else                base = 2;
    r = (abort_at >= 2) ? abort_at : base + hold;
    last = ((kind <= 1 && g + SLOT > r) ? g + SLOT : r) + 2;
    for (int k = 1; k <= last; k++) begin
      as_n  = (k < r) ? 1'b0 : 1'b1;
      a     = (k == 1) ? code : 3'($urandom);
      ovl   = (k == 2) ? ovl_s : 1'($urandom);
      ovr_n = (k == 2) ? ovr_s : 1'($urandom);
      xrdy  = (kind == 4) ? 1'(k >= xdel) : 1'($urandom);
      if (kind <= 1 && k >= 3 && k <= g && (p0 + k) % SLOT == 0) dbr_n = 1'(k == g);
      else dbr_n = 1'($urandom);
      @(posedge clk); #1;
      ph = (ph + 1) % SLOT;
      gr = (kind <= 1) && (g < r);
      en = gr && k >= g && k <= g + SLOT - 1;
      case (kind)
        0, 1:    dt = gr && k >= g + DTP && k <= r - 1;
        2:       dt = k >= 2 + ROMW && k <= r - 1;
        4:       dt = k >= t && k <= r - 1;
        default: dt = 1'b0;
      endcase
      deny = 0;
      if (kind <= 1 && k < g && k < r && k >= s0) deny = (k - s0) / SLOT + 1;
      chk_all(k, ~(en && kind == 0), ~(en && kind == 1),
              ~(kind == 2 && k >= 2 && k <= r - 1), ~(kind == 3 && k >= 2 && k <= r - 1),
              ~dt, ~(deny >= BLS));
    end
  endtask

  initial begin
    int n;
    logic found;
    rst = 1'b1; as_n = 1'b1; a = '0; ovl = 1'b0; ovr_n = 1'b1; xrdy = 1'b0; dbr_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    rst = 1'b0; ph = 0;

    // Reset in the middle of a granted RAM slot.
    as_n = 1'b0; a = 3'd0; ovl = 1'b0; dbr_n = 1'b1;
    found = 1'b0; n = 0;
    while (!found && n < 40) begin
      @(posedge clk); #1;
      n++;
      found = (re_n == 1'b0) && (phase == 3'd5);
    end
    chk("midchip_reached", n, 8'(found), 8'(1'b1));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ph = 0;
      chk_all(-1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    end
    rst = 1'b0; as_n = 1'b1;

    idle_to(6);
    run_txn(3'd0, 1'b0, 1'b1, 0, 0, 4, 0);   // free RAM access from phase 6
    run_txn(3'd6, 1'b0, 1'b1, 4, 0, 3, 0);   // register access denied 4 slots
    run_txn(3'd0, 1'b1, 1'b1, 0, 0, 2, 0);   // overlay ROM
    run_txn(3'd0, 1'b0, 1'b1, 1, 0, 2, 0);   // RAM with overlay off
    run_txn(3'd7, 1'b0, 1'b1, 0, 0, 1, 0);   // ROM
    run_txn(3'd5, 1'b0, 1'b1, 0, 0, 5, 0);   // CIA
    run_txn(3'd2, 1'b0, 1'b1, 0, 12, 3, 0);  // external, late XRDY
    run_txn(3'd2, 1'b0, 1'b0, 0, 0, 4, 0);   // external override
    run_txn(3'd6, 1'b0, 1'b1, 3, 0, 0, 12);  // abort while waiting for a slot

    for (int i = 0; i < 40; i++) begin
      logic [2:0] c;
      int nd, xd, hd, ab;
      c  = 3'($urandom);
      nd = int'($urandom_range(0, 4));
      xd = int'($urandom_range(2, 12));
      hd = int'($urandom_range(0, 6));
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 14)) : 0;
      idle_to(int'($urandom_range(0, SLOT - 1)));
      run_txn(c, 1'($urandom), 1'($urandom), nd, xd, hd, ab);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
